// File: rtl/irq_controller_if.sv
// irq_controller_if
//   Bundles the CPU-side signals of the interrupt controller: the small
//   configuration register bus and the REQ/ACK/DONE interrupt handshake.
//   Modports:
//     master - CPU core side (drives writes, ack, done; observes request)
//     slave  - controller side (irq_controller uses this one)
//   Signals:
//     cfg_we, cfg_addr, cfg_wdata   register write strobe / select / data
//     cfg_rdata                     combinational read data of cfg_addr
//     int_req, int_vec, int_id      request, vector address, channel number
//     int_ack, int_done             CPU accept pulse, RETI pulse
//     busy                          controller is in its service phase
interface irq_controller_if #(
  parameter int DATA_W = 16
);
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [DATA_W-1:0] cfg_rdata;
  logic              int_req;
  logic [DATA_W-1:0] int_vec;
  logic [3:0]        int_id;
  logic              int_ack;
  logic              int_done;
  logic              busy;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
    input  cfg_rdata, int_req, int_vec, int_id, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
    output cfg_rdata, int_req, int_vec, int_id, busy
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
//   Vectored interrupt controller with N_IRQ channels for the 16-bit CPU.
//   Every channel has a synchroniser, an edge/level mode bit and a mask bit.
//   The lowest-numbered eligible channel wins. One request is presented at a
//   time and its id/vector are frozen until the CPU acknowledges it; no
//   nesting while the CPU services it.
//   Ports:
//     clk     system clock, rising edge
//     rst     synchronous reset, active low
//     irq_in  asynchronous interrupt sources, one bit per channel
//     gie     CPU global interrupt enable
//     bus     irq_controller_if.slave: config registers + REQ/ACK/DONE
//   Register map (cfg_addr): 0 MASK, 1 MODE (1 = edge), 2 PENDING (W1C for
//   edge channels), 3 BASE. Bits above N_IRQ read 0 and ignore writes.
module irq_controller #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_STRIDE  = 2,
  parameter int DATA_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             gie,
  irq_controller_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_BASE = 2'd3;

  logic [N_IRQ-1:0]  sync_reg [SYNC_STAGES];
  logic [N_IRQ-1:0]  prev_reg;
  logic [N_IRQ-1:0]  mask_reg;
  logic [N_IRQ-1:0]  mode_reg;
  logic [N_IRQ-1:0]  pending_reg;
  logic [N_IRQ-1:0]  pending_next;
  logic [DATA_W-1:0] base_reg;
  logic [1:0]        state_reg;
  logic [3:0]        id_reg;
  logic [DATA_W-1:0] vec_reg;

  logic [N_IRQ-1:0]  sync_out;
  logic [N_IRQ-1:0]  edge_det;
  logic [N_IRQ-1:0]  eligible;
  logic [3:0]        winner;
  logic [DATA_W-1:0] vec_next;
  logic              pend_wr;
  logic [DATA_W-1:0] rdata;

  // Synchroniser chain and edge history
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= '0;
      end
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
      prev_reg <= sync_out;
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign edge_det = sync_out & ~prev_reg;
  assign pend_wr  = bus.cfg_we && (bus.cfg_addr == ADDR_PEND);

  // Per-channel pending update. Level channels simply track the synchronised
  // input. Edge channels latch an edge and clear on W1C or on the ACK of
  // their own request; a new edge in the clearing cycle takes precedence.
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_chan
      logic w1c_hit;
      logic ack_hit;
      assign w1c_hit = pend_wr & bus.cfg_wdata[gi];
      assign ack_hit = (state_reg == ST_REQ) & bus.int_ack & (id_reg == 4'(gi));
      assign pending_next[gi] = mode_reg[gi]
                              ? (edge_det[gi] | (pending_reg[gi] & ~w1c_hit & ~ack_hit))
                              : sync_out[gi];
    end
  endgenerate

  // Configuration registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_reg    <= '0;
      mode_reg    <= '0;
      pending_reg <= '0;
      base_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          ADDR_MASK: mask_reg <= bus.cfg_wdata[N_IRQ-1:0];
          ADDR_MODE: mode_reg <= bus.cfg_wdata[N_IRQ-1:0];
          ADDR_BASE: base_reg <= bus.cfg_wdata;
          default:   ;
        endcase
      end
    end
  end

  // Fixed priority: scanning downwards leaves the lowest eligible index
  assign eligible = pending_reg & mask_reg;

  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 4'(i);
      end
    end
  end

  assign vec_next = base_reg + DATA_W'(VEC_STRIDE * int'(winner));

  // Handshake FSM. id/vector are captured on leaving IDLE and held, so the
  // CPU always sees a stable request even if priorities shift meanwhile.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      id_reg    <= '0;
      vec_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (gie && (eligible != '0)) begin
            state_reg <= ST_REQ;
            id_reg    <= winner;
            vec_reg   <= vec_next;
          end
        end
        ST_REQ: begin
          if (bus.int_ack) begin
            state_reg <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (bus.int_done) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      ADDR_MASK: rdata[N_IRQ-1:0] = mask_reg;
      ADDR_MODE: rdata[N_IRQ-1:0] = mode_reg;
      ADDR_PEND: rdata[N_IRQ-1:0] = pending_reg;
      ADDR_BASE: rdata            = base_reg;
      default:   rdata            = '0;
    endcase
  end

  assign bus.cfg_rdata = rdata;
  assign bus.int_req   = (state_reg == ST_REQ);
  assign bus.busy      = (state_reg == ST_SERVICE);
  assign bus.int_id    = id_reg;
  assign bus.int_vec   = vec_reg;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//   Self-checking bench for irq_controller (N_IRQ=8, SYNC_STAGES=2,
//   VEC_STRIDE=2, DATA_W=16): register-file vector table, directed corner
//   sequences, then randomized traffic against a behavioural model.
module tb_irq_controller;
  localparam int N      = 8;
  localparam int SYNC   = 2;
  localparam int STRIDE = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_in;
  logic         gie;

  irq_controller_if #(.DATA_W(16)) bus ();

  irq_controller #(
    .N_IRQ(N), .SYNC_STAGES(SYNC), .VEC_STRIDE(STRIDE), .DATA_W(16)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .gie(gie), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
    bus.cfg_addr = a;
    #1;
    chk(name, bus.cfg_rdata, exp);
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.int_done = 1'b1; tick(); bus.int_done = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (bus.int_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_req_seen"}, bus.int_req, 1);
  endtask

  // ---------------- behavioural reference model ----------------
  // hist[0] is the irq_in value applied before the most recent edge; the
  // synchronised view is that history delayed by the synchroniser depth.
  bit [N-1:0] hist [SYNC+1];
  bit [N-1:0] m_mask, m_mode, m_pend;
  bit [15:0]  m_base, m_vec;
  bit         m_req, m_busy;
  bit [3:0]   m_id;

  task automatic model_reset();
    for (int k = 0; k <= SYNC; k++) hist[k] = '0;
    m_mask = '0; m_mode = '0; m_pend = '0; m_base = '0;
    m_req = 0; m_busy = 0; m_id = '0; m_vec = '0;
  endtask

  function automatic bit [15:0] model_read(input bit [1:0] a);
    case (a)
      2'd0:    return {8'h00, m_mask};
      2'd1:    return {8'h00, m_mode};
      2'd2:    return {8'h00, m_pend};
      default: return m_base;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit [N-1:0] irq, input bit g,
                            input bit we, input bit [1:0] a, input bit [15:0] wd,
                            input bit ack, input bit done);
    bit [N-1:0] s, p, np, elig;
    int w;
    if (!r) begin
      model_reset();
      return;
    end
    s = hist[SYNC-1];
    p = hist[SYNC];
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        bit rise, clr;
        rise = s[i] && !p[i];
        clr  = (we && a == 2'd2 && wd[i]) || (m_req && ack && m_id == 4'(i));
        np[i] = rise || (m_pend[i] && !clr);
      end else begin
        np[i] = s[i];
      end
    end
    if (m_req) begin
      if (ack) begin m_req = 0; m_busy = 1; end
    end else if (m_busy) begin
      if (done) m_busy = 0;
    end else if (g) begin
      elig = m_pend & m_mask;
      if (elig != 0) begin
        w = 0;
        while (!elig[w]) w++;
        m_req = 1;
        m_id  = 4'(w);
        m_vec = 16'(int'(m_base) + w * STRIDE);
      end
    end
    if (we) begin
      case (a)
        2'd0: m_mask = wd[N-1:0];
        2'd1: m_mode = wd[N-1:0];
        2'd3: m_base = wd;
        default: ;
      endcase
    end
    m_pend = np;
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = irq;
  endtask

  // ---------------- register-file vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  raddr;
    logic [15:0] exp;
    string       name;
  } cfg_vec_t;

  cfg_vec_t vecs [8];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit [N-1:0] r_irq;
    bit [1:0]   r_addr;
    bit [15:0]  r_wd;
    bit         r_rst, r_gie, r_we, r_ack, r_done;

    vecs[0] = '{1'b1, 2'd0, 16'hFFFF, 2'd0, 16'h00FF, "mask_wr_ff"};
    vecs[1] = '{1'b1, 2'd1, 16'hA5A5, 2'd1, 16'h00A5, "mode_wr_a5"};
    vecs[2] = '{1'b1, 2'd3, 16'h1234, 2'd3, 16'h1234, "base_wr_1234"};
    vecs[3] = '{1'b0, 2'd0, 16'h0000, 2'd0, 16'h00FF, "mask_hold"};
    vecs[4] = '{1'b1, 2'd2, 16'hFFFF, 2'd2, 16'h0000, "pend_w1c_idle"};
    vecs[5] = '{1'b1, 2'd0, 16'h0000, 2'd0, 16'h0000, "mask_wr_0"};
    vecs[6] = '{1'b1, 2'd1, 16'h0000, 2'd1, 16'h0000, "mode_wr_0"};
    vecs[7] = '{1'b1, 2'd3, 16'hFFFF, 2'd3, 16'hFFFF, "base_wr_ffff"};

    rst = 1'b0; irq_in = 8'hFF; gie = 1'b0;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.int_ack = 0; bus.int_done = 0;

    // Reset
    tick(); tick();
    chk("rst_req", bus.int_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_id", bus.int_id, 0);
    chk("rst_vec", bus.int_vec, 0);
    for (int a = 0; a < 4; a++) rd(2'(a), 16'h0000, "rst_rdata");
    $display("reset: outputs and registers checked");
    irq_in = '0; rst = 1'b1;
    tick(); tick(); tick();

    // Register table
    for (int v = 0; v < 8; v++) begin
      bus.cfg_we = vecs[v].we; bus.cfg_addr = vecs[v].waddr; bus.cfg_wdata = vecs[v].wdata;
      tick();
      bus.cfg_we = 1'b0;
      rd(vecs[v].raddr, vecs[v].exp, vecs[v].name);
      $display("vec %0d %s: addr %0d rdata %h", v, vecs[v].name, vecs[v].raddr, bus.cfg_rdata);
    end

    // Single edge IRQ: 3-cycle latency
    wr(2'd3, 16'h0100); wr(2'd0, 16'h0008); wr(2'd1, 16'h0008);
    gie = 1'b1;
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("edge_latency_c%0d", c), bus.int_req, (c == 3) ? 1 : 0);
    end
    chk("edge_vec", bus.int_vec, 16'h0106);
    chk("edge_id", bus.int_id, 3);
    pulse_ack();
    chk("edge_busy", bus.busy, 1);
    chk("edge_req_after_ack", bus.int_req, 0);
    rd(2'd2, 16'h0000, "edge_pend_cleared");
    pulse_done();
    chk("edge_done_busy", bus.busy, 0);
    tick(); tick();
    chk("edge_no_rereq", bus.int_req, 0);
    $display("single edge: ch3 vec 0106 serviced");

    // Priority and freeze
    wr(2'd0, 16'h00FF); wr(2'd1, 16'h00FF);
    irq_in = 8'h24;
    wait_req("prio1");
    chk("prio1_id", bus.int_id, 2);
    chk("prio1_vec", bus.int_vec, 16'h0104);
    irq_in = 8'h25;
    tick(); tick(); tick(); tick();
    chk("freeze_req", bus.int_req, 1);
    chk("freeze_id", bus.int_id, 2);
    pulse_ack(); tick(); pulse_done();
    wait_req("prio2");
    chk("prio2_id", bus.int_id, 0);
    chk("prio2_vec", bus.int_vec, 16'h0100);
    pulse_ack(); pulse_done();
    wait_req("prio3");
    chk("prio3_id", bus.int_id, 5);
    chk("prio3_vec", bus.int_vec, 16'h010A);
    pulse_ack(); pulse_done();
    irq_in = 8'h00;
    $display("priority: order 2,0,5 serviced");

    // Level mode and mask
    wr(2'd1, 16'h0000); wr(2'd0, 16'h0000);
    irq_in = 8'h02;
    tick(); tick(); tick(); tick();
    chk("level_masked_req", bus.int_req, 0);
    rd(2'd2, 16'h0002, "level_pend_bit1");
    wr(2'd0, 16'h0002);
    tick();
    chk("level_unmask_req", bus.int_req, 1);
    chk("level_id", bus.int_id, 1);
    pulse_ack();
    irq_in = 8'h00;
    tick(); tick(); tick(); tick();
    pulse_done();
    tick(); tick(); tick();
    chk("level_released_req", bus.int_req, 0);
    chk("level_released_busy", bus.busy, 0);
    $display("level: ch1 serviced, released");

    // Set/clear collision on ch4
    wr(2'd1, 16'h0010);
    irq_in = 8'h10;
    tick(); tick();
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_wdata = 16'h0010;
    tick();
    bus.cfg_we = 1'b0;
    rd(2'd2, 16'h0010, "collide_set_wins");
    wr(2'd2, 16'h0010);
    rd(2'd2, 16'h0000, "w1c_clears");
    irq_in = 8'h00;
    $display("collision: set wins over W1C");

    // GIE gating and reset in SERVICE
    gie = 1'b0;
    wr(2'd1, 16'h0040); wr(2'd0, 16'h0040);
    irq_in = 8'h40;
    tick();
    irq_in = 8'h00;
    tick(); tick(); tick(); tick(); tick();
    chk("gie_off_req", bus.int_req, 0);
    rd(2'd2, 16'h0040, "gie_off_pend");
    gie = 1'b1;
    tick();
    chk("gie_on_req", bus.int_req, 1);
    chk("gie_on_id", bus.int_id, 6);
    chk("gie_on_vec", bus.int_vec, 16'h010C);
    pulse_ack();
    chk("svc_busy", bus.busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_req", bus.int_req, 0);
    rd(2'd2, 16'h0000, "midrst_pend");
    rd(2'd0, 16'h0000, "midrst_mask");
    rd(2'd3, 16'h0000, "midrst_base");
    $display("gie/reset: ch6 gated then reset in service");

    // Randomized traffic against the model
    rst = 1'b0; irq_in = '0; gie = 1'b0;
    tick();
    model_reset();
    rst = 1'b1;
    r_irq = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("rnd_req", bus.int_req, m_req);
      chk("rnd_busy", bus.busy, m_busy);
      if (m_req || m_busy) chk("rnd_id", bus.int_id, m_id);
      if (m_req) chk("rnd_vec", bus.int_vec, m_vec);

      r_rst  = ($urandom_range(0, 299) != 0);
      r_irq  = r_irq ^ N'($urandom & $urandom & $urandom);
      r_gie  = ($urandom_range(0, 9) != 0);
      r_we   = ($urandom_range(0, 5) == 0);
      r_addr = 2'($urandom);
      r_wd   = 16'($urandom);
      r_ack  = m_req  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      r_done = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (m_req && r_ack && r_rst)
        $display("rnd cyc %0d: ack ch %0d vec %h", cyc, m_id, m_vec);

      rst = r_rst; irq_in = r_irq; gie = r_gie;
      bus.cfg_we = r_we; bus.cfg_addr = r_addr; bus.cfg_wdata = r_wd;
      bus.int_ack = r_ack; bus.int_done = r_done;
      #1;
      chk("rnd_rdata", bus.cfg_rdata, model_read(r_addr));
      @(posedge clk);
      model_step(r_rst, r_irq, r_gie, r_we, r_addr, r_wd, r_ack, r_done);
      #1;
    end
    rst = 1'b1; bus.cfg_we = 0; bus.int_ack = 0; bus.int_done = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
